fp_sub_arbiter: RTL



---
 rtl/fp_sub_arbiter_if.sv | 22 ++
 rtl/fp_sub_arbiter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/fp_sub_arbiter_if.sv
// Requester-side bundle for the shared subtract arbiter: packed operand requests and one-hot result strobes.
interface fp_sub_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned W       = 32
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*W-1:0] req_a;
    logic [NUM_REQ*W-1:0] req_b;
    logic [NUM_REQ-1:0]   resp_valid;
    logic [W-1:0]         resp_data;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/fp_sub_arbiter.sv
// Round-robin sharing of one pipelined single-precision subtract unit among NUM_REQ requesters,
// with a tag pipeline for result routing and an enable/drain FSM for clean quiescing.
module fp_sub_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned W       = 32,
    parameter int unsigned SUB_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    fp_sub_arbiter_if.slave      bus,
    output logic [W-1:0]         sub_a,
    output logic [W-1:0]         sub_b,
    input  logic [W-1:0]         sub_c,
    output logic [3:0]           inflight,
    output logic                 idle
);

    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

    state_t              state;
    logic [ID_W-1:0]     ptr;
    logic [ID_W-1:0]     win;
    logic                found;
    logic                grant_ok;
    logic                issue;
    logic                cap;
    logic [NUM_REQ-1:0]  ready_c;
    logic [W-1:0]        win_a;
    logic [W-1:0]        win_b;
    logic [3:0]          inflight_nxt;
    int unsigned         idx;
    logic [SUB_LAT-1:0]  tag_v;
    logic [ID_W-1:0]     tag_id [SUB_LAT];

    // Rotating priority search starting at ptr; grants blocked in reset, DRAIN, or when disabled.
    always_comb begin
        win      = '0;
        found    = 1'b0;
        idx      = 0;
        grant_ok = !rst && en && (state != DRAIN);
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(ptr) + i) % NUM_REQ;
            if (!found && bus.req_valid[ID_W'(idx)]) begin
                found = 1'b1;
                win   = ID_W'(idx);
            end
        end
        ready_c = '0;
        if (grant_ok && found) begin
            ready_c[win] = 1'b1;
        end
        issue = grant_ok && found;
    end

    // Operand mux for the winning requester.
    always_comb begin
        win_a = '0;
        win_b = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == win) begin
                win_a = bus.req_a[i*W +: W];
                win_b = bus.req_b[i*W +: W];
            end
        end
    end

    // Issue and capture on the same edge cancel out.
    always_comb begin
        cap          = tag_v[SUB_LAT-1];
        inflight_nxt = inflight;
        if (issue && !cap) begin
            inflight_nxt = inflight + 4'd1;
        end else if (!issue && cap) begin
            inflight_nxt = inflight - 4'd1;
        end
    end

    assign bus.req_ready = ready_c;

    // Operand registers, rr pointer, tag pipeline and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sub_a          <= '0;
            sub_b          <= '0;
            ptr            <= '0;
            tag_v          <= '0;
            bus.resp_valid <= '0;
            bus.resp_data  <= '0;
            inflight       <= '0;
        end else begin
            if (issue) begin
                sub_a <= win_a;
                sub_b <= win_b;
                ptr   <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + ID_W'(1);
            end
            tag_v[0] <= issue;
            for (int unsigned i = 1; i < SUB_LAT; i++) begin
                tag_v[i] <= tag_v[i-1];
            end
            bus.resp_valid <= '0;
            if (cap) begin
                bus.resp_valid[tag_id[SUB_LAT-1]] <= 1'b1;
                bus.resp_data                     <= sub_c;
            end
            inflight <= inflight_nxt;
        end
    end

    // Tag ids are only meaningful alongside tag_v, so they need no reset.
    always_ff @(posedge clk) begin
        tag_id[0] <= win;
        for (int unsigned i = 1; i < SUB_LAT; i++) begin
            tag_id[i] <= tag_id[i-1];
        end
    end

    // Enable/drain FSM; idle is registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idle  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        state <= BUSY;
                        idle  <= 1'b0;
                    end
                end
                BUSY: begin
                    if (inflight_nxt == 4'd0 && !issue) begin
                        state <= IDLE;
                        idle  <= 1'b1;
                    end else if (!en) begin
                        state <= DRAIN;
                        idle  <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (inflight_nxt == 4'd0) begin
                        state <= IDLE;
                        idle  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    idle  <= 1'b1;
                end
            endcase
        end
    end

endmodule
